pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipe; drives hold/bubble controls of IF/ID, ID/EX, EX/MEM, MEM/WB regs.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 14 +
 rtl/pipe_hazard_ctrl_if.sv | 39 +++
 rtl/pipe_hazard_ctrl_load_use_detect.sv | 18 +
 rtl/pipe_hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package pipe_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      DRAIN    = 2'd2,
      HALT     = 2'd3
   } pipe_ctrl_state_t;

   // Encoding the pipeline registers load when flushed (addi x0,x0,0).
   localparam logic [31:0] NOP_INSTR_HEX = 32'h0000_0013;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the sequencer (slave).
interface pipe_hazard_ctrl_if;
   logic [4:0]  rs1_IFID;
   logic [4:0]  rs2_IFID;
   logic        useRs1_IFID;
   logic        useRs2_IFID;
   logic [4:0]  rd_IDEX;
   logic        memRead_IDEX;
   logic        branchTaken_EX;
   logic        memReq_EXMEM;
   logic        dmem_ready;
   logic        ECALL_EXMEM;
   logic        resume;
   logic        pc_hold;
   logic        stall_IFID;
   logic        stall_IDEX;
   logic        stall_EXMEM;
   logic        flush_IFID;
   logic        flush_IDEX;
   logic        flush_MEMWB;
   logic        halted;
   logic        mem_fault;
   logic [31:0] perf_stall_cnt;
   logic [31:0] perf_flush_cnt;

   modport master (
      output rs1_IFID, rs2_IFID, useRs1_IFID, useRs2_IFID, rd_IDEX, memRead_IDEX,
             branchTaken_EX, memReq_EXMEM, dmem_ready, ECALL_EXMEM, resume,
      input  pc_hold, stall_IFID, stall_IDEX, stall_EXMEM, flush_IFID, flush_IDEX,
             flush_MEMWB, halted, mem_fault, perf_stall_cnt, perf_flush_cnt
   );

   modport slave (
      input  rs1_IFID, rs2_IFID, useRs1_IFID, useRs2_IFID, rd_IDEX, memRead_IDEX,
             branchTaken_EX, memReq_EXMEM, dmem_ready, ECALL_EXMEM, resume,
      output pc_hold, stall_IFID, stall_IDEX, stall_EXMEM, flush_IFID, flush_IDEX,
             flush_MEMWB, halted, mem_fault, perf_stall_cnt, perf_flush_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Flags a load in ID/EX whose destination feeds a source of the instruction in IF/ID.
module pipe_hazard_ctrl_load_use_detect (
   input  logic [4:0] rs1_IFID,
   input  logic [4:0] rs2_IFID,
   input  logic       useRs1_IFID,
   input  logic       useRs2_IFID,
   input  logic [4:0] rd_IDEX,
   input  logic       memRead_IDEX,
   output logic       hazard
);
   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit = useRs1_IFID && (rd_IDEX == rs1_IFID);
   assign rs2_hit = useRs2_IFID && (rd_IDEX == rs2_IFID);
   // x0 is never written, so a load targeting it cannot create a dependency.
   assign hazard  = memRead_IDEX && (rd_IDEX != 5'd0) && (rs1_hit || rs2_hit);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe: load-use, branch squash, dmem freeze, ECALL drain.
// Optional perf counters built when PIPE_HAZARD_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT  = 256,
   parameter int DRAIN_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   pipe_hazard_ctrl_if.slave hz
);
   localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
   localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

   pipe_ctrl_state_t     state_q, state_d;
   logic [WAIT_W-1:0]    wait_q, wait_d;
   logic [DRAIN_W-1:0]   drain_q, drain_d;
   logic                 load_use;
   logic                 frozen;
   logic                 br_flush;
   logic                 pc_hold, stall_ifid, stall_idex, stall_exmem;
   logic                 flush_ifid, flush_idex, flush_memwb, halted, mem_fault;

   pipe_hazard_ctrl_load_use_detect u_load_use (
      .rs1_IFID     (hz.rs1_IFID),
      .rs2_IFID     (hz.rs2_IFID),
      .useRs1_IFID  (hz.useRs1_IFID),
      .useRs2_IFID  (hz.useRs2_IFID),
      .rd_IDEX      (hz.rd_IDEX),
      .memRead_IDEX (hz.memRead_IDEX),
      .hazard       (load_use)
   );

   // Once in MEM_WAIT the access is still outstanding, so only ready matters.
   assign frozen = (state_q == MEM_WAIT) ? !hz.dmem_ready
                 : (state_q == RUN) && hz.memReq_EXMEM && !hz.dmem_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         wait_q  <= '0;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         drain_q <= drain_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      drain_d     = drain_q;
      pc_hold     = 1'b0;
      stall_ifid  = 1'b0;
      stall_idex  = 1'b0;
      stall_exmem = 1'b0;
      flush_ifid  = 1'b0;
      flush_idex  = 1'b0;
      flush_memwb = 1'b0;
      halted      = 1'b0;
      mem_fault   = 1'b0;
      br_flush    = 1'b0;
      unique case (state_q)
         RUN, MEM_WAIT: begin
            if (frozen) begin
               pc_hold     = 1'b1;
               stall_ifid  = 1'b1;
               stall_idex  = 1'b1;
               stall_exmem = 1'b1;
               flush_memwb = 1'b1;
               // The RUN freeze cycle counts as the first wait cycle.
               if (state_q == RUN) begin
                  state_d = MEM_WAIT;
                  wait_d  = WAIT_W'(1);
               end else if (wait_q >= WAIT_W'(MEM_TIMEOUT - 1)) begin
                  mem_fault = 1'b1;
                  state_d   = HALT;
                  wait_d    = '0;
               end else begin
                  wait_d = wait_q + WAIT_W'(1);
               end
            end else begin
               state_d = RUN;
               wait_d  = '0;
               if (hz.branchTaken_EX) begin
                  flush_ifid = 1'b1;
                  flush_idex = 1'b1;
                  br_flush   = 1'b1;
               end else if (load_use) begin
                  pc_hold    = 1'b1;
                  stall_ifid = 1'b1;
                  flush_idex = 1'b1;
               end
               if (hz.ECALL_EXMEM) begin
                  state_d = DRAIN;
                  drain_d = '0;
               end
            end
         end
         DRAIN: begin
            pc_hold    = 1'b1;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            if (drain_q >= DRAIN_W'(DRAIN_CYCLES - 1)) begin
               state_d = HALT;
               drain_d = '0;
            end else begin
               drain_d = drain_q + DRAIN_W'(1);
            end
         end
         HALT: begin
            halted      = 1'b1;
            pc_hold     = 1'b1;
            stall_ifid  = 1'b1;
            stall_idex  = 1'b1;
            stall_exmem = 1'b1;
            flush_memwb = 1'b1;
            if (hz.resume) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   // Outputs are forced low for the whole time reset is held.
   assign hz.pc_hold     = pc_hold     && !rst;
   assign hz.stall_IFID  = stall_ifid  && !rst;
   assign hz.stall_IDEX  = stall_idex  && !rst;
   assign hz.stall_EXMEM = stall_exmem && !rst;
   assign hz.flush_IFID  = flush_ifid  && !rst;
   assign hz.flush_IDEX  = flush_idex  && !rst;
   assign hz.flush_MEMWB = flush_memwb && !rst;
   assign hz.halted      = halted      && !rst;
   assign hz.mem_fault   = mem_fault   && !rst;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] flush_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (pc_hold && (state_q != HALT)) stall_cnt_q <= stall_cnt_q + 32'd1;
         if (br_flush)                     flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign hz.perf_stall_cnt = stall_cnt_q;
   assign hz.perf_flush_cnt = flush_cnt_q;
`else
   assign hz.perf_stall_cnt = 32'd0;
   assign hz.perf_flush_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MEM_TIMEOUT=4, DRAIN_CYCLES=2).
module tb_pipe_hazard_ctrl;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   pipe_hazard_ctrl_if hz ();

   pipe_hazard_ctrl #(
      .MEM_TIMEOUT  (4),
      .DRAIN_CYCLES (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   // {pc_hold, stall_IFID, stall_IDEX, stall_EXMEM, flush_IFID, flush_IDEX, flush_MEMWB, halted, mem_fault}
   logic [8:0] outs;
   assign outs = {hz.pc_hold, hz.stall_IFID, hz.stall_IDEX, hz.stall_EXMEM,
                  hz.flush_IFID, hz.flush_IDEX, hz.flush_MEMWB, hz.halted, hz.mem_fault};

   localparam logic [8:0] NONE  = 9'b000000000;
   localparam logic [8:0] LU    = 9'b110001000;
   localparam logic [8:0] BR    = 9'b000011000;
   localparam logic [8:0] FRZ   = 9'b111100100;
   localparam logic [8:0] FRZ_F = 9'b111100101;
   localparam logic [8:0] DRN   = 9'b100011000;
   localparam logic [8:0] HLT   = 9'b111100110;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
   localparam logic [31:0] EXP_STALL_T1 = 32'd2;
   localparam logic [31:0] EXP_FLUSH_T2 = 32'd1;
`else
   localparam logic [31:0] EXP_STALL_T1 = 32'd0;
   localparam logic [31:0] EXP_FLUSH_T2 = 32'd0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      hz.rs1_IFID       = 5'd0;
      hz.rs2_IFID       = 5'd0;
      hz.useRs1_IFID    = 1'b0;
      hz.useRs2_IFID    = 1'b0;
      hz.rd_IDEX        = 5'd0;
      hz.memRead_IDEX   = 1'b0;
      hz.branchTaken_EX = 1'b0;
      hz.memReq_EXMEM   = 1'b0;
      hz.dmem_ready     = 1'b0;
      hz.ECALL_EXMEM    = 1'b0;
      hz.resume         = 1'b0;
   endtask

   task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2);
      hz.memRead_IDEX = 1'b1;
      hz.rd_IDEX      = rd;
      hz.rs1_IFID     = rs1;
      hz.useRs1_IFID  = u1;
      hz.rs2_IFID     = rs2;
      hz.useRs2_IFID  = u2;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b0;
      idle();
      #1 rst = 1'b1;
      hz.branchTaken_EX = 1'b1;
      #1 chk("reset_outputs_gated", 32'(outs), 32'(NONE));
      chk("reset_perf_stall", hz.perf_stall_cnt, 32'd0);
      chk("reset_perf_flush", hz.perf_flush_cnt, 32'd0);
      cyc();
      idle();
      rst = 1'b0;
      #1 chk("idle_run", 32'(outs), 32'(NONE));
      cyc();

      // load-use: lw x5 in ID/EX, add rs1=x5
      set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
      #1 chk("lu_rs1", 32'(outs), 32'(LU));
      cyc();
      idle();
      #1 chk("lu_bubble_next", 32'(outs), 32'(NONE));
      cyc();
      set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
      #1 chk("lu_rd_x0", 32'(outs), 32'(NONE));
      set_lu(5'd7, 5'd3, 1'b1, 5'd7, 1'b1);
      #1 chk("lu_rs2", 32'(outs), 32'(LU));
      cyc();
      set_lu(5'd7, 5'd3, 1'b1, 5'd7, 1'b0);
      #1 chk("lu_rs2_unused", 32'(outs), 32'(NONE));
      hz.memRead_IDEX = 1'b0;
      hz.useRs2_IFID  = 1'b1;
      #1 chk("lu_not_load", 32'(outs), 32'(NONE));
      chk("perf_stall_after_lu", hz.perf_stall_cnt, EXP_STALL_T1);
      idle();
      cyc();

      // branch overrides load-use
      set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
      hz.branchTaken_EX = 1'b1;
      #1 chk("branch_over_lu", 32'(outs), 32'(BR));
      cyc();
      idle();
      #1 chk("perf_flush_after_br", hz.perf_flush_cnt, EXP_FLUSH_T2);
      cyc();

      // memory wait 3 cycles, load-use and branch masked while frozen
      hz.memReq_EXMEM = 1'b1;
      hz.dmem_ready   = 1'b0;
      set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
      hz.branchTaken_EX = 1'b1;
      #1 chk("mw_freeze1", 32'(outs), 32'(FRZ));
      cyc();
      #1 chk("mw_freeze2", 32'(outs), 32'(FRZ));
      cyc();
      #1 chk("mw_freeze3", 32'(outs), 32'(FRZ));
      cyc();
      hz.dmem_ready     = 1'b1;
      hz.branchTaken_EX = 1'b0;
      #1 chk("mw_release_reeval", 32'(outs), 32'(LU));
      cyc();
      idle();
      #1 chk("mw_back_in_run", 32'(outs), 32'(NONE));
      cyc();

      // timeout: ready never rises
      hz.memReq_EXMEM = 1'b1;
      #1 chk("to_c1", 32'(outs), 32'(FRZ));
      cyc();
      #1 chk("to_c2", 32'(outs), 32'(FRZ));
      cyc();
      #1 chk("to_c3", 32'(outs), 32'(FRZ));
      cyc();
      #1 chk("to_c4_fault", 32'(outs), 32'(FRZ_F));
      cyc();
      idle();
      #1 chk("to_halted", 32'(outs), 32'(HLT));
      cyc();
      #1 chk("halt_stays", 32'(outs), 32'(HLT));
      hz.resume = 1'b1;
      #1 chk("halt_resume_cycle", 32'(outs), 32'(HLT));
      cyc();
      hz.resume = 1'b0;
      #1 chk("resumed_run", 32'(outs), 32'(NONE));
      cyc();

      // ECALL drain then halt
      hz.ECALL_EXMEM = 1'b1;
      #1 chk("ecall_detect", 32'(outs), 32'(NONE));
      cyc();
      hz.ECALL_EXMEM = 1'b0;
      #1 chk("drain1", 32'(outs), 32'(DRN));
      cyc();
      #1 chk("drain2", 32'(outs), 32'(DRN));
      cyc();
      #1 chk("ecall_halted", 32'(outs), 32'(HLT));
      hz.resume = 1'b1;
      cyc();
      hz.resume = 1'b0;
      #1 chk("ecall_resumed", 32'(outs), 32'(NONE));

      // resume outside HALT has no effect
      hz.resume = 1'b1;
      #1 chk("resume_in_run", 32'(outs), 32'(NONE));
      cyc();
      hz.resume = 1'b0;
      #1 chk("resume_in_run_next", 32'(outs), 32'(NONE));
      cyc();

      // async reset while in MEM_WAIT
      hz.memReq_EXMEM = 1'b1;
      hz.dmem_ready   = 1'b0;
      cyc();
      #1 chk("pre_rst_mem_wait", 32'(outs), 32'(FRZ));
      rst = 1'b1;
      #1 chk("rst_mid_wait", 32'(outs), 32'(NONE));
      cyc();
      hz.memReq_EXMEM = 1'b0;
      rst = 1'b0;
      #1 chk("after_rst_run", 32'(outs), 32'(NONE));
      chk("after_rst_perf_stall", hz.perf_stall_cnt, 32'd0);
      chk("after_rst_perf_flush", hz.perf_flush_cnt, 32'd0);
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
